// File: rtl/cordic_vectoring.sv
// Iterative CORDIC, vectoring mode: (x, y) -> gain-compensated magnitude and atan2(y, x)
// as a binary angle (full circle = 2^WIDTH). One micro-rotation per clock, valid/ready both sides.
module cordic_vectoring #(
  parameter int WIDTH      = 16,
  parameter int ITERATIONS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] y_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic        [WIDTH-1:0] magnitude_o,
  output logic signed [WIDTH-1:0] angle_o
);
  // x/y carry GX fraction bits below the input LSB and z carries GZ below the angle LSB,
  // so shift and table truncation stay well under one output LSB.
  localparam int GX = 8;
  localparam int GZ = (32 - WIDTH < 8) ? 32 - WIDTH : 8;
  localparam int DW = WIDTH + 2 + GX;
  localparam int ZW = WIDTH + GZ;
  localparam int PW = DW + WIDTH;
  localparam int CW = 6;
  localparam logic [31:0]       K32     = 32'h9B74_EDA8;
  localparam logic [WIDTH-1:0]  K       = K32[31 -: WIDTH];
  localparam logic [ZW-1:0]     QUARTER = ZW'(1) << (ZW - 2);
  localparam logic [31:0] ATAN32 [32] = '{
    32'h2000_0000, 32'h12E4_051D, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2E, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2F9, 32'h0000_517C,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A2F, 32'h0000_0517,
    32'h0000_028B, 32'h0000_0145, 32'h0000_00A2, 32'h0000_0051,
    32'h0000_0028, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000
  };

  typedef enum logic [1:0] {IDLE, ROTATE, SCALE, DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [DW-1:0]     x_q, x_d, y_q, y_d, xs, ys;
  logic        [ZW-1:0]     z_q, z_d;
  logic        [CW-1:0]     iter_q, iter_d;
  logic                     zero_q, zero_d;
  logic        [WIDTH-1:0]  mag_q, mag_d;
  logic signed [WIDTH-1:0]  ang_q, ang_d;

  function automatic logic signed [DW-1:0] widen(input logic signed [WIDTH-1:0] v);
    return {{2{v[WIDTH-1]}}, v, {GX{1'b0}}};
  endfunction

  function automatic logic [ZW-1:0] atan_at(input logic [4:0] idx);
    return ATAN32[idx][31 -: ZW];
  endfunction

  function automatic logic [WIDTH-1:0] round_angle(input logic [ZW-1:0] zv);
    logic [ZW-1:0] r;
    r = zv;
    if (GZ > 0) r = zv + (ZW'(1) << (GZ > 0 ? GZ - 1 : 0));
    return WIDTH'(r >> GZ);
  endfunction

  // x is non-negative once vectoring finishes; round-to-nearest then clamp to WIDTH bits
  function automatic logic [WIDTH-1:0] scale_sat(input logic signed [DW-1:0] xv);
    logic [PW-1:0] prod;
    logic [PW-1:0] rounded;
    if (xv[DW-1]) return '0;
    prod    = PW'($unsigned(xv)) * PW'(K);
    rounded = (prod + (PW'(1) << (WIDTH + GX - 1))) >> (WIDTH + GX);
    if (rounded > PW'({WIDTH{1'b1}})) return '1;
    return rounded[WIDTH-1:0];
  endfunction

  assign ready_o     = (state_q == IDLE);
  assign valid_o     = (state_q == DONE);
  assign magnitude_o = mag_q;
  assign angle_o     = ang_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    ang_d   = ang_q;
    xs      = x_q >>> iter_q;
    ys      = y_q >>> iter_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          zero_d  = (x_i == '0) && (y_i == '0);
          iter_d  = '0;
          state_d = ROTATE;
          // Fold the left half-plane into the right one with a +/-90 deg start angle
          if (!x_i[WIDTH-1]) begin
            x_d = widen(x_i);
            y_d = widen(y_i);
            z_d = '0;
          end else if (!y_i[WIDTH-1]) begin
            x_d = widen(y_i);
            y_d = -widen(x_i);
            z_d = QUARTER;
          end else begin
            x_d = -widen(y_i);
            y_d = widen(x_i);
            z_d = -QUARTER;
          end
        end
      end
      ROTATE: begin
        if (!y_q[DW-1]) begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + atan_at(iter_q[4:0]);
        end else begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - atan_at(iter_q[4:0]);
        end
        iter_d = iter_q + 1'b1;
        if (iter_q == CW'(ITERATIONS - 1)) state_d = SCALE;
      end
      SCALE: begin
        mag_d   = zero_q ? '0 : scale_sat(x_q);
        ang_d   = zero_q ? '0 : round_angle(z_q);
        state_d = DONE;
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      ang_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      ang_q   <= ang_d;
    end
  end
endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: driver pushes real-valued atan2/hypot expectations,
// an independent monitor checks every cycle the DUT presents a result.
module tb_cordic_vectoring;
  localparam int  W  = 16;
  localparam int  N  = 16;
  localparam real PI = 3.14159265358979323846;

  logic                clk = 1'b0;
  logic                rst_n, valid_i, ready_i;
  logic                ready_o, valid_o;
  logic signed [W-1:0] x_i, y_i, angle_o;
  logic        [W-1:0] magnitude_o;

  typedef struct { real mag; real ang; bit zero; int acc; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   checks = 0, failures = 0, cyc = 0;
  bit   rand_rdy = 1'b0, prev_valid = 1'b0;
  real  tol, dm, da;
  int   a1, a2, a3;

  cordic_vectoring #(.WIDTH(W), .ITERATIONS(N)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .x_i(x_i), .y_i(y_i), .valid_o(valid_o), .ready_i(ready_i),
    .magnitude_o(magnitude_o), .angle_o(angle_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input int x, input int y, input int acc);
    exp_t m;
    m.zero = (x == 0) && (y == 0);
    m.mag  = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    m.ang  = m.zero ? 0.0 : $atan2(real'(y), real'(x)) * (2.0 ** W) / (2.0 * PI);
    m.acc  = acc;
    return m;
  endfunction

  // Monitor: compare whatever the DUT presents against the head of the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_valid", 1, 0);
        end else begin
          e = exp_q[0];
          if (!prev_valid) chk(cyc - e.acc == N + 1, "latency", cyc - e.acc, N + 1);
          chk(!ready_o, "ready_while_done", int'(ready_o), 0);
          if (e.zero) begin
            chk(magnitude_o == '0, "zero_magnitude", int'(magnitude_o), 0);
            chk(angle_o == '0, "zero_angle", int'(angle_o), 0);
          end else begin
            tol = 3.0 + 0.001 * e.mag;
            dm  = real'(int'(magnitude_o)) - e.mag;
            chk(dm <= tol && dm >= -tol, "magnitude", int'(magnitude_o), $rtoi(e.mag + 0.5));
            da = real'(int'(angle_o)) - e.ang;
            while (da >= 2.0 ** (W - 1)) da -= 2.0 ** W;
            while (da < -(2.0 ** (W - 1))) da += 2.0 ** W;
            chk(da <= 3.0 && da >= -3.0, "angle", int'(angle_o), $rtoi(e.ang));
          end
          if (ready_i) void'(exp_q.pop_front());
        end
      end
      prev_valid = valid_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int x, input int y, output int acc);
    int waited;
    waited = 0;
    acc    = -1;
    while (!ready_o && waited < 200) begin
      tick();
      waited++;
    end
    if (!ready_o) begin
      chk(1'b0, "ready_timeout", 0, 1);
      return;
    end
    valid_i = 1'b1;
    x_i     = W'(x);
    y_i     = W'(y);
    acc     = cyc + 1;
    exp_q.push_back(model(x, y, acc));
    tick();
    valid_i = 1'b0;
    x_i     = W'($urandom);
    y_i     = W'($urandom);
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      tick();
      waited++;
    end
    if (exp_q.size() != 0) begin
      chk(1'b0, "drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    int acc, x, y, sh;
    logic signed [W-1:0] r;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    x_i     = '0;
    y_i     = '0;
    tick();
    tick();
    chk(ready_o == 1'b1, "reset_ready", int'(ready_o), 1);
    chk(valid_o == 1'b0, "reset_valid", int'(valid_o), 0);
    chk(magnitude_o == '0, "reset_magnitude", int'(magnitude_o), 0);
    chk(angle_o == '0, "reset_angle", int'(angle_o), 0);
    rst_n = 1'b1;
    tick();

    send(1000, 0, acc);
    send(0, 1000, acc);
    send(1000, 1000, acc);
    send(-1000, -1000, acc);
    send(-1000, 0, acc);
    send(-32768, -32768, acc);
    send(32767, -32768, acc);
    send(-32768, 0, acc);
    send(0, 0, acc);
    drain();

    // Back-to-back acceptance with ready_i held high
    send(700, -300, a1);
    send(-1500, 2500, a2);
    send(20000, 15000, a3);
    chk(a2 - a1 == N + 3, "spacing_1", a2 - a1, N + 3);
    chk(a3 - a2 == N + 3, "spacing_2", a3 - a2, N + 3);
    drain();

    // Backpressure: result held, extra valid_i pulses ignored
    ready_i = 1'b0;
    send(3000, -4000, acc);
    for (int k = 0; k < 40 && !valid_o; k++) begin
      valid_i = k[0];
      x_i = 16'sd1111;
      y_i = 16'sd2222;
      tick();
    end
    chk(valid_o == 1'b1, "bp_valid_seen", int'(valid_o), 1);
    for (int k = 0; k < 10; k++) begin
      valid_i = ~k[0];
      x_i = -16'sd5000;
      y_i = 16'sd123;
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    chk(ready_o == 1'b1, "bp_ready_after", int'(ready_o), 1);
    chk(valid_o == 1'b0, "bp_valid_dropped", int'(valid_o), 0);
    for (int k = 0; k < 30; k++) tick();
    chk(exp_q.size() == 0, "bp_queue_empty", exp_q.size(), 0);

    // Randomized vectors with random downstream backpressure
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      do begin
        sh = $urandom_range(0, 5);
        r = W'($urandom);
        x = int'(r) >>> sh;
        r = W'($urandom);
        y = int'(r) >>> sh;
      end while (real'(x) * real'(x) + real'(y) * real'(y) < 1.0e6);
      send(x, y, acc);
    end
    drain();
    rand_rdy = 1'b0;
    ready_i  = 1'b1;
    tick();

    // Reset mid-operation discards the in-flight vector
    send(1234, 567, acc);
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    chk(valid_o == 1'b0, "rst_mid_valid", int'(valid_o), 0);
    chk(ready_o == 1'b1, "rst_mid_ready", int'(ready_o), 1);
    chk(magnitude_o == '0, "rst_mid_magnitude", int'(magnitude_o), 0);
    chk(angle_o == '0, "rst_mid_angle", int'(angle_o), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) tick();
    chk(ready_o == 1'b1, "rst_release_ready", int'(ready_o), 1);
    send(0, -500, acc);
    drain();
    for (int k = 0; k < 5; k++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
